mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit.sv | 124 ++++++++++++
 tb/tb_mdu_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers. Operands are latched on accept and the
// result is written to HI/LO when a fixed-length busy countdown expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_e;

  logic [CW-1:0] r_count;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  op_e           r_op;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_valid;

  assign busy = (r_count != '0);
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_abs_a = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_abs_b = r_b[31] ? (~r_b + 32'd1) : r_b;

  always_comb begin
    w_q_mag     = '0;
    w_r_mag     = '0;
    w_res_hi    = r_hi;
    w_res_lo    = r_lo;
    w_res_valid = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_res_hi    = w_prod_s[63:32];
        w_res_lo    = w_prod_s[31:0];
        w_res_valid = 1'b1;
      end
      OP_MULTU: begin
        w_res_hi    = w_prod_u[63:32];
        w_res_lo    = w_prod_u[31:0];
        w_res_valid = 1'b1;
      end
      OP_DIV: begin
        if (r_b != '0) begin
          w_q_mag     = w_abs_a / w_abs_b;
          w_r_mag     = w_abs_a % w_abs_b;
          w_res_lo    = (r_a[31] ^ r_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
          w_res_hi    = r_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
          w_res_valid = 1'b1;
        end
      end
      OP_DIVU: begin
        if (r_b != '0) begin
          w_res_lo    = r_a / r_b;
          w_res_hi    = r_a % r_b;
          w_res_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= OP_NONE;
    end else if (busy) begin
      r_count <= r_count - CW'(1);
      if (r_count == CW'(1) && w_res_valid) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if (start) begin
      case (op_e'(mdu_op))
        OP_MULT, OP_MULTU: begin
          r_a     <= A;
          r_b     <= B;
          r_op    <= op_e'(mdu_op);
          r_count <= CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          r_a     <= A;
          r_b     <= B;
          r_op    <= op_e'(mdu_op);
          r_count <= CW'(DIV_CYCLES);
        end
        OP_MTHI: r_hi <= A;
        OP_MTLO: r_lo <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: arithmetic results, busy window length, ignore rules and reset abort.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int unsigned total = 0;
  int unsigned fails = 0;
  int unsigned n;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; returns one negedge later, after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; A = 32'h5555_AAAA; B = 32'hAAAA_5555;
  endtask

  // Counts busy cycles until busy falls, bounded.
  task automatic wait_done(output int unsigned cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) check("busy_timeout", 32'(cycles), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = '0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_hold_hi", HI, 32'h0);
    wait_done(n);
    check("multu_cycles", 32'(n), 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_hold_lo", LO, 32'hFFFF_FFFE);
    wait_done(n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // Issued on the first idle cycle after completion.
    issue(4'd4, 32'd7, 32'd2);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("divu_cycles", 32'(n), 32'd10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0000_0000);

    issue(4'd5, 32'h1234_5678, 32'h0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'h8000_0000);
    issue(4'd6, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    check("mtlo_hi", HI, 32'h1234_5678);

    issue(4'd4, 32'd100, 32'd0);
    wait_done(n);
    check("dz_cycles", 32'(n), 32'd10);
    check("dz_hi", HI, 32'h1234_5678);
    check("dz_lo", LO, 32'h9ABC_DEF0);

    issue(4'd7, 32'hCAFE_0001, 32'd3);
    check("rsv7_busy", 32'(busy), 32'd0);
    issue(4'd15, 32'hCAFE_0002, 32'd3);
    issue(4'd0, 32'hCAFE_0003, 32'd3);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_hi", HI, 32'h1234_5678);
    check("rsv_lo", LO, 32'h9ABC_DEF0);

    // mthi attempt in busy cycle 2 must be dropped; operand inputs also wander.
    issue(4'd1, 32'd3, 32'd5);
    @(negedge clk);
    issue(4'd5, 32'hDEAD_BEEF, 32'h0);
    check("busy_mthi_hold", HI, 32'h1234_5678);
    wait_done(n);
    check("busy_mthi_cycles", 32'(n), 32'd3);
    check("busy_mthi_hi", HI, 32'h0);
    check("busy_mthi_lo", LO, 32'd15);

    // Reset in busy cycle 4 aborts the divide.
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", HI, 32'h0);
    check("abort_late_lo", LO, 32'h0);

    issue(4'd5, 32'h0000_00AA, 32'h0);
    check("mthi_after", HI, 32'h0000_00AA);
    reset = 1'b1;
    issue(4'd6, 32'h0000_00BB, 32'h0);
    reset = 1'b0;
    check("rst_prio_lo", LO, 32'h0);
    check("rst_prio_hi", HI, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
